tail_light_controller: RTL and testbench

//   Sequential turn-signal (Thunderbird-style) controller for 8 tail-light LEDs, 4 per side.
//   A left/right request runs a one-shot outward "sweep" on that side's lamps, then returns to idle.
//   If the request is still held at the end of the sweep, the sweep repeats.

---
 rtl/tail_light_controller.sv | 130 +++++++++++++
 tb/tb_tail_light_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tail_light_controller.sv
// tail_light_controller: Thunderbird-style sequential turn-signal controller, 4 lamps per side.
// Latency: a request sampled at edge k shows the first sweep step on LEDS right after edge k.
//   LEDS is registered, with no combinational path from the inputs.
// Backpressure: none. Requests are sampled only in IDLE and ignored while a sweep runs.
//
// Ports:
//   clk    - system clock; all state changes on its rising edge
//   reset  - asynchronous, active-high; clears state, step counter and LEDS at once
//   left   - left-turn request, level-sensitive, synchronous to clk
//   right  - right-turn request, level-sensitive, synchronous to clk
//   LEDS   - [7:4] left lamps (LEDS[4] innermost), [3:0] right lamps (LEDS[3] innermost)
//
// Parameter:
//   STEP_CYCLES - cycles each sweep step is held (>= 1)
//
// Optional feature macro: HAZARD_EN.
//   When HAZARD_EN is defined, left and right together in IDLE flash all eight lamps.
//   When it is undefined, left and right together start a left sweep (left has priority).

module tail_light_controller #(
  parameter int STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  output logic [7:0] LEDS
);

  // The step counter is at least 1 bit wide, even when STEP_CYCLES is 1.
  localparam int            CW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    L1, L2, L3, L4,
    R1, R2, R3, R4
`ifdef HAZARD_EN
    , HZ
`endif
  } state_t;

  state_t        state;
  state_t        state_nxt;
  state_t        succ;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          step_done;

  // Lamp pattern for each state. LEDS is loaded from the pattern of the next state,
  // so the output stays a plain register that tracks the state register.
  function automatic logic [7:0] decode(input state_t s);
    logic [7:0] v;
    v = 8'h00;
    case (s)
      L1:      v = 8'h10;
      L2:      v = 8'h30;
      L3:      v = 8'h70;
      L4:      v = 8'hF0;
      R1:      v = 8'h08;
      R2:      v = 8'h0C;
      R3:      v = 8'h0E;
      R4:      v = 8'h0F;
`ifdef HAZARD_EN
      HZ:      v = 8'hFF;
`endif
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  assign step_done = (cnt == LAST);

  // Where each sweep state goes once its step has run out. The last step of
  // every sweep, and the hazard flash, return to IDLE. This forces at least
  // one IDLE cycle between sweeps.
  always_comb begin
    succ = IDLE;
    case (state)
      L1:      succ = L2;
      L2:      succ = L3;
      L3:      succ = L4;
      R1:      succ = R2;
      R2:      succ = R3;
      R3:      succ = R4;
      default: succ = IDLE;
    endcase
  end

  // Next-state and step-counter logic. The counter restarts at zero on every
  // state change, so each step lasts exactly STEP_CYCLES cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    if (state == IDLE) begin
`ifdef HAZARD_EN
      if (left && right) begin
        state_nxt = HZ;
      end else if (left) begin
        state_nxt = L1;
      end else if (right) begin
        state_nxt = R1;
      end
`else
      if (left) begin
        state_nxt = L1;
      end else if (right) begin
        state_nxt = R1;
      end
`endif
    end else if (step_done) begin
      state_nxt = succ;
    end else begin
      cnt_nxt   = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      LEDS  <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      LEDS  <= decode(state_nxt);
    end
  end

endmodule

// File: tb/tb_tail_light_controller.sv
// tb_tail_light_controller: directed checks of the turn-signal controller.
// Latency: expects LEDS to show a new pattern one edge after the inputs are applied.
// Backpressure: not applicable; inputs are driven on negedges and LEDS is sampled 1 ns after posedge.

module tb_tail_light_controller;

  logic       clk;
  logic       reset;
  logic       left;
  logic       right;
  logic [7:0] leds;
  logic       left3;
  logic       right3;
  logic [7:0] leds3;

  int n_cmp;
  int n_bad;

  tail_light_controller #(.STEP_CYCLES(1)) dut (
    .clk   (clk),
    .reset (reset),
    .left  (left),
    .right (right),
    .LEDS  (leds)
  );

  tail_light_controller #(.STEP_CYCLES(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .left  (left3),
    .right (right3),
    .LEDS  (leds3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       l;
    logic       r;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic l, input logic r, input logic [7:0] e, input string nm);
    vec_t v;
    v.l    = l;
    v.r    = r;
    v.exp  = e;
    v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: LEDS got %02h, want %02h at %0t", nm, act, e, $time);
    end
  endtask

  // Called at a negedge: apply inputs, let one rising edge pass, check, then return at the next negedge.
  task automatic step(input logic l, input logic r, input logic [7:0] e, input string nm);
    left  = l;
    right = r;
    @(posedge clk);
    #1;
    check(nm, leds, e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 100000", $time);
    $fatal(1);
  end

  logic [7:0] exp3[$];

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    left   = 1'b0;
    right  = 1'b0;
    left3  = 1'b0;
    right3 = 1'b0;
    reset  = 1'b1;

    // Left pulse: a single-cycle request runs one full sweep.
    add(1, 0, 8'h10, "lpulse_1");
    add(0, 0, 8'h30, "lpulse_2");
    add(0, 0, 8'h70, "lpulse_3");
    add(0, 0, 8'hF0, "lpulse_4");
    add(0, 0, 8'h00, "lpulse_idle");
    add(0, 0, 8'h00, "lpulse_stay");
    // Left held for 7 cycles: the second sweep completes after release.
    add(1, 0, 8'h10, "lhold_1");
    add(1, 0, 8'h30, "lhold_2");
    add(1, 0, 8'h70, "lhold_3");
    add(1, 0, 8'hF0, "lhold_4");
    add(1, 0, 8'h00, "lhold_gap");
    add(1, 0, 8'h10, "lhold_5");
    add(1, 0, 8'h30, "lhold_6");
    add(0, 0, 8'h70, "lhold_7");
    add(0, 0, 8'hF0, "lhold_8");
    add(0, 0, 8'h00, "lhold_idle");
    // Right pulse.
    add(0, 1, 8'h08, "rpulse_1");
    add(0, 0, 8'h0C, "rpulse_2");
    add(0, 0, 8'h0E, "rpulse_3");
    add(0, 0, 8'h0F, "rpulse_4");
    add(0, 0, 8'h00, "rpulse_idle");
    // Right raised during a left sweep, including at the L4 edge: no side switch.
    add(1, 0, 8'h10, "lsw_1");
    add(0, 1, 8'h30, "lsw_2");
    add(0, 1, 8'h70, "lsw_3");
    add(0, 1, 8'hF0, "lsw_4");
    add(0, 0, 8'h00, "lsw_idle");
    add(0, 0, 8'h00, "lsw_stay");
    // Both requests in IDLE.
`ifdef HAZARD_EN
    add(1, 1, 8'hFF, "both_hz1");
    add(1, 1, 8'h00, "both_gap1");
    add(1, 1, 8'hFF, "both_hz2");
    add(0, 0, 8'h00, "both_gap2");
    add(0, 0, 8'h00, "both_idle");
`else
    add(1, 1, 8'h10, "both_1");
    add(1, 1, 8'h30, "both_2");
    add(1, 1, 8'h70, "both_3");
    add(1, 1, 8'hF0, "both_4");
    add(0, 0, 8'h00, "both_idle");
`endif
    // A single request still sweeps.
    add(0, 1, 8'h08, "rafter_1");
    add(0, 0, 8'h0C, "rafter_2");
    add(0, 0, 8'h0E, "rafter_3");
    add(0, 0, 8'h0F, "rafter_4");
    add(0, 0, 8'h00, "rafter_idle");

    // Reset state: reset is held across edges while the inputs request a sweep.
    #2;
    check("reset_async", leds, 8'h00);
    left = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_held", leds, 8'h00);
    check("reset_held3", leds3, 8'h00);
    left  = 1'b0;
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].l, vecs[i].r, vecs[i].exp, vecs[i].name);
    end

    // Reset asserted mid-sweep clears LEDS before the next clock edge.
    step(1, 0, 8'h10, "rst_pre1");
    step(0, 0, 8'h30, "rst_pre2");
    @(posedge clk);
    #2;
    check("rst_pre3", leds, 8'h70);
    reset = 1'b1;
    #1;
    check("rst_mid_async", leds, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 8'h00, "rst_after1");
    step(0, 0, 8'h00, "rst_after2");
    step(0, 0, 8'h00, "rst_after3");

    // STEP_CYCLES=3: each step is held exactly three cycles.
    for (int k = 0; k < 3; k++) exp3.push_back(8'h10);
    for (int k = 0; k < 3; k++) exp3.push_back(8'h30);
    for (int k = 0; k < 3; k++) exp3.push_back(8'h70);
    for (int k = 0; k < 3; k++) exp3.push_back(8'hF0);
    exp3.push_back(8'h00);
    exp3.push_back(8'h00);
    left3 = 1'b1;
    foreach (exp3[i]) begin
      @(posedge clk);
      #1;
      check($sformatf("step3_%0d", i), leds3, exp3[i]);
      @(negedge clk);
      left3 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
